// File: rtl/conv_out_packer_if.sv
// rtl/conv_out_packer_if.sv - control, result-stream and packed-word signals of the output packer
interface conv_out_packer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_UNITS = 8
);
    logic                             start;
    logic [15:0]                      row_len;
    logic [15:0]                      num_rows;
    logic                             r_valid;
    logic [DATA_WIDTH-1:0]            T_out;
    logic                             r_rdy;
    logic [DATA_WIDTH*CONV_UNITS-1:0] m_data;
    logic                             m_valid;
    logic                             m_ready;
    logic                             m_eol;
    logic                             m_last;
    logic                             busy;
    logic                             done;

    modport master (
        output start, row_len, num_rows, r_valid, T_out, m_ready,
        input  r_rdy, m_data, m_valid, m_eol, m_last, busy, done
    );

    modport slave (
        input  start, row_len, num_rows, r_valid, T_out, m_ready,
        output r_rdy, m_data, m_valid, m_eol, m_last, busy, done
    );
endinterface

// File: rtl/conv_out_packer.sv
// rtl/conv_out_packer.sv - packs CONV_UNITS results per word into a 2-deep output FIFO with row/frame tags
module conv_out_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_UNITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    conv_out_packer_if.slave bus
);
    // CONV_UNITS must be at least 2: the top lane is never stored, it goes straight into the pushed word
    localparam int WORD_W = DATA_WIDTH * CONV_UNITS;
    localparam int ASM_W  = DATA_WIDTH * (CONV_UNITS - 1);
    localparam int LANE_W = $clog2(CONV_UNITS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CONV_UNITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [LANE_W-1:0]   r_lane_cnt;
    logic [15:0]         r_col_cnt;
    logic [15:0]         r_row_cnt;
    logic [15:0]         r_row_len;
    logic [15:0]         r_num_rows;
    logic [ASM_W-1:0]    r_asm;

    logic [WORD_W-1:0]   r_fifo_data [2];
    logic [1:0]          r_fifo_eol;
    logic [1:0]          r_fifo_last;
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_fifo_cnt;

    logic                w_start_ok;
    logic                w_rdy;
    logic                w_beat;
    logic                w_push;
    logic                w_pop;
    logic                w_m_valid;
    logic                w_row_end;
    logic                w_frame_end;
    logic [WORD_W-1:0]   w_word;

    assign w_start_ok  = bus.start && (bus.row_len != 16'd0) && (bus.num_rows != 16'd0);
    assign w_row_end   = (r_col_cnt == r_row_len - 16'd1);
    assign w_frame_end = w_row_end && (r_row_cnt == r_num_rows - 16'd1);

    // The final lane may still be taken on a full FIFO when the head pops in the same cycle
    assign w_rdy     = (r_state == S_RUN) &&
                       ((r_lane_cnt != LAST_LANE) || (r_fifo_cnt != 2'd2) || bus.m_ready);
    assign w_beat    = bus.r_valid && w_rdy;
    assign w_push    = w_beat && (r_lane_cnt == LAST_LANE);
    assign w_m_valid = (r_fifo_cnt != 2'd0);
    assign w_pop     = w_m_valid && bus.m_ready;
    assign w_word    = {bus.T_out, r_asm};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = w_start_ok ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_push && w_frame_end) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_pop && (r_fifo_cnt == 2'd1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_col_cnt  <= 16'd0;
            r_row_cnt  <= 16'd0;
            r_row_len  <= 16'd0;
            r_num_rows <= 16'd0;
            r_asm      <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_row_len  <= bus.row_len;
                r_num_rows <= bus.num_rows;
                r_lane_cnt <= '0;
                r_col_cnt  <= 16'd0;
                r_row_cnt  <= 16'd0;
            end
            if (w_beat) begin
                if (r_lane_cnt == LAST_LANE) begin
                    r_lane_cnt <= '0;
                end else begin
                    r_lane_cnt <= r_lane_cnt + LANE_W'(1);
                    r_asm[DATA_WIDTH*r_lane_cnt +: DATA_WIDTH] <= bus.T_out;
                end
            end
            if (w_push) begin
                if (w_row_end) begin
                    r_col_cnt <= 16'd0;
                    r_row_cnt <= r_row_cnt + 16'd1;
                end else begin
                    r_col_cnt <= r_col_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_eol     <= 2'b00;
            r_fifo_last    <= 2'b00;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_word;
                r_fifo_eol[r_wr_ptr]  <= w_row_end;
                r_fifo_last[r_wr_ptr] <= w_frame_end;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Outputs read as zero whenever the FIFO is empty so stale entries never leak out
    assign bus.r_rdy   = w_rdy;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = w_m_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.m_eol   = w_m_valid && r_fifo_eol[r_rd_ptr];
    assign bus.m_last  = w_m_valid && r_fifo_last[r_rd_ptr];
    assign bus.busy    = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign bus.done    = (r_state == S_DONE);
endmodule
